// File: rtl/can_timing_pkg.sv
// Shared types, default widths and helpers for the CAN bit-timing generator.
package can_timing_pkg;

  typedef enum logic [1:0] {
    SEG_SYNC = 2'd0,
    SEG_1    = 2'd1,
    SEG_2    = 2'd2
  } seg_e;

  localparam int unsigned DEF_BRP_W  = 32'd6;
  localparam int unsigned DEF_SEG1_W = 32'd4;
  localparam int unsigned DEF_SEG2_W = 32'd3;
  localparam int unsigned DEF_SJW_W  = 32'd2;

  // Nominal bit length in tq: SYNC (1) + SEG1 (tseg1+1) + SEG2 (tseg2+1).
  function automatic int unsigned nominal_bit_tq(input int unsigned tseg1,
                                                 input int unsigned tseg2);
    return tseg1 + tseg2 + 32'd3;
  endfunction

endpackage

// File: rtl/tq_prescaler.sv
// Time-quantum prescaler: counts 0..brp and pulses tq_tick on the last count.
module tq_prescaler #(
  parameter int unsigned BRP_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clear,
  input  logic [BRP_W-1:0] brp,
  output logic             tq_tick
);

  logic [BRP_W-1:0] cnt_q;
  logic [BRP_W-1:0] cnt_d;

  // >= rather than == so a stray count above brp still wraps.
  assign tq_tick = en & ~clear & (cnt_q >= brp);

  // Next count: clear wins, otherwise advance/wrap only while enabled.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = {BRP_W{1'b0}};
    end else if (en) begin
      if (tq_tick) begin
        cnt_d = {BRP_W{1'b0}};
      end else begin
        cnt_d = cnt_q + {{(BRP_W-1){1'b0}}, 1'b1};
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= {BRP_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/can_bit_timing.sv
// CAN bit-timing generator: SYNC/SEG1/SEG2 framing, sample/transmit strobes, hard sync.
// Soft resynchronisation is built only when BIT_TIMING_RESYNC_EN is defined.
module can_bit_timing
  import can_timing_pkg::*;
#(
  parameter int unsigned BRP_W  = DEF_BRP_W,
  parameter int unsigned SEG1_W = DEF_SEG1_W,
  parameter int unsigned SEG2_W = DEF_SEG2_W,
  parameter int unsigned SJW_W  = DEF_SJW_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [BRP_W-1:0]  brp,
  input  logic [SEG1_W-1:0] tseg1,
  input  logic [SEG2_W-1:0] tseg2,
  input  logic [SJW_W-1:0]  sjw,
  input  logic              rx,
  input  logic              hard_sync_en,
  output logic              tq_tick,
  output logic              sample_pt,
  output logic              tx_pt,
  output logic              bit_val,
  output logic [1:0]        seg
);

  // One bit wider than tseg1 so an extended SEG1 never wraps.
  localparam int unsigned CNT_W = SEG1_W + 1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [BRP_W-1:0]  brp_q;
  logic [SEG1_W-1:0] tseg1_q;
  logic [SEG2_W-1:0] tseg2_q;
  logic [SJW_W-1:0]  sjw_q;
  seg_e              seg_q, seg_d;
  logic [CNT_W-1:0]  tq_cnt_q, tq_cnt_d;
  logic [CNT_W-1:0]  seg1_end_q, seg1_end_d, seg1_end_eff;
  logic [CNT_W-1:0]  seg2_end_q, seg2_end_d, seg2_end_eff;
  logic              early_q, early_d, early_eff;
  logic              rs_done_q, rs_done_d, rs_set_s;
  logic              rx_prev_q;
  logic              bit_val_q, bit_val_d;
  logic              latch_cfg_s;
  logic              sample_s, tx_s;
  logic              edge_s, hsync_s, pres_tick_s, tick_s;

  assign edge_s  = en & rx_prev_q & ~rx;
  assign hsync_s = edge_s & hard_sync_en;

  tq_prescaler #(.BRP_W(BRP_W)) u_prescaler (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .clear   (hsync_s),
    .brp     (brp_q),
    .tq_tick (pres_tick_s)
  );

  assign tick_s = pres_tick_s & ~rst;

`ifdef BIT_TIMING_RESYNC_EN
  logic             rs_ok_s;
  logic [CNT_W-1:0] sjw_p1_s, k_p1_s, r_s;

  assign rs_ok_s  = edge_s & ~hard_sync_en & ~rs_done_q & bit_val_q;
  assign sjw_p1_s = CNT_W'(sjw_q) + CNT_ONE;
  assign k_p1_s   = tq_cnt_q + CNT_ONE;
  assign r_s      = seg2_end_q - tq_cnt_q + CNT_ONE;

  // Soft resync: lengthen SEG1 or shorten/terminate SEG2 by at most sjw+1 tq.
  always_comb begin
    seg1_end_eff = seg1_end_q;
    seg2_end_eff = seg2_end_q;
    early_eff    = early_q;
    rs_set_s     = 1'b0;
    if (rs_ok_s) begin
      case (seg_q)
        SEG_1: begin
          rs_set_s     = 1'b1;
          seg1_end_eff = seg1_end_q + ((k_p1_s < sjw_p1_s) ? k_p1_s : sjw_p1_s);
        end
        SEG_2: begin
          rs_set_s = 1'b1;
          if (r_s <= sjw_p1_s) begin
            early_eff = 1'b1;
          end else begin
            seg2_end_eff = seg2_end_q - sjw_p1_s;
          end
        end
        default: rs_set_s = 1'b0;
      endcase
    end else begin
      rs_set_s = 1'b0;
    end
  end
`else
  logic unused_cfg_s;
  assign unused_cfg_s = ^{sjw_q, rs_done_q};

  // Without soft resync the segment ends are always nominal.
  always_comb begin
    seg1_end_eff = seg1_end_q;
    seg2_end_eff = seg2_end_q;
    early_eff    = early_q;
    rs_set_s     = 1'b0;
  end
`endif

  // Segment FSM: advances on tq_tick; hard sync restarts the bit in SEG1.
  always_comb begin
    seg_d       = seg_q;
    tq_cnt_d    = tq_cnt_q;
    seg1_end_d  = seg1_end_eff;
    seg2_end_d  = seg2_end_eff;
    early_d     = early_eff;
    rs_done_d   = rs_done_q | rs_set_s;
    latch_cfg_s = 1'b0;
    sample_s    = 1'b0;
    tx_s        = 1'b0;
    if (hsync_s) begin
      seg_d      = SEG_1;
      tq_cnt_d   = {CNT_W{1'b0}};
      seg1_end_d = CNT_W'(tseg1_q);
      early_d    = 1'b0;
      rs_done_d  = 1'b0;
    end else if (tick_s) begin
      case (seg_q)
        SEG_SYNC: begin
          seg_d      = SEG_1;
          tq_cnt_d   = {CNT_W{1'b0}};
          seg1_end_d = CNT_W'(tseg1_q);
        end
        SEG_1: begin
          if (tq_cnt_q >= seg1_end_eff) begin
            seg_d      = SEG_2;
            tq_cnt_d   = {CNT_W{1'b0}};
            seg2_end_d = CNT_W'(tseg2_q);
            sample_s   = 1'b1;
          end else begin
            tq_cnt_d = tq_cnt_q + CNT_ONE;
          end
        end
        SEG_2: begin
          if (early_eff || (tq_cnt_q >= seg2_end_eff)) begin
            tx_s     = 1'b1;
            tq_cnt_d = {CNT_W{1'b0}};
            early_d  = 1'b0;
            // An early edge skips SYNC and starts the next bit's SEG1 directly.
            if (early_eff) begin
              seg_d      = SEG_1;
              seg1_end_d = CNT_W'(tseg1_q);
            end else begin
              seg_d       = SEG_SYNC;
              latch_cfg_s = 1'b1;
              rs_done_d   = 1'b0;
            end
          end else begin
            tq_cnt_d = tq_cnt_q + CNT_ONE;
          end
        end
        default: begin
          seg_d    = SEG_SYNC;
          tq_cnt_d = {CNT_W{1'b0}};
        end
      endcase
    end else begin
      seg_d = seg_q;
    end
  end

  assign bit_val_d = sample_s ? rx : bit_val_q;

  // State, configuration and sampled-bit registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      brp_q      <= brp;
      tseg1_q    <= tseg1;
      tseg2_q    <= tseg2;
      sjw_q      <= sjw;
      seg_q      <= SEG_SYNC;
      tq_cnt_q   <= {CNT_W{1'b0}};
      seg1_end_q <= {CNT_W{1'b0}};
      seg2_end_q <= {CNT_W{1'b0}};
      early_q    <= 1'b0;
      rs_done_q  <= 1'b0;
      rx_prev_q  <= 1'b1;
      bit_val_q  <= 1'b1;
    end else begin
      if (latch_cfg_s) begin
        brp_q   <= brp;
        tseg1_q <= tseg1;
        tseg2_q <= tseg2;
        sjw_q   <= sjw;
      end
      seg_q      <= seg_d;
      tq_cnt_q   <= tq_cnt_d;
      seg1_end_q <= seg1_end_d;
      seg2_end_q <= seg2_end_d;
      early_q    <= early_d;
      rs_done_q  <= rs_done_d;
      rx_prev_q  <= rx;
      bit_val_q  <= bit_val_d;
    end
  end

  assign tq_tick   = tick_s;
  assign sample_pt = sample_s;
  assign tx_pt     = tx_s;
  assign bit_val   = bit_val_q;
  assign seg       = seg_q;

endmodule

// File: tb/tb_can_bit_timing.sv
// Scoreboard bench for can_bit_timing; expectations follow BIT_TIMING_RESYNC_EN.
module tb_can_bit_timing;

  logic       clk = 1'b0;
  logic       rst, en, hard_sync_en, rx;
  logic [5:0] brp;
  logic [3:0] tseg1;
  logic [2:0] tseg2;
  logic [1:0] sjw;
  logic       tq_tick, sample_pt, tx_pt, bit_val;
  logic [1:0] seg;

  typedef struct {
    int         cyc;
    logic [1:0] kind;   // 2'b01 sample_pt, 2'b10 tx_pt
    logic       bv;
  } ev_t;

  ev_t  sbq[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic mon_en = 1'b0;
  logic bv_pending = 1'b0;
  logic bv_exp = 1'b1;

  can_bit_timing dut (
    .clk(clk), .rst(rst), .en(en), .brp(brp), .tseg1(tseg1), .tseg2(tseg2),
    .sjw(sjw), .rx(rx), .hard_sync_en(hard_sync_en), .tq_tick(tq_tick),
    .sample_pt(sample_pt), .tx_pt(tx_pt), .bit_val(bit_val), .seg(seg)
  );

  always #5 clk = ~clk;

  // Strobe monitor: pops the scoreboard whenever a strobe appears.
  always @(negedge clk) begin
    if (mon_en) begin
      if (bv_pending) begin
        checks++;
        bv_pending = 1'b0;
        if (bit_val !== bv_exp) begin
          errors++;
          $display("FAIL bit_val cyc=%0d got %b expected %b", cyc, bit_val, bv_exp);
        end
      end
      if (sample_pt === 1'b1 || tx_pt === 1'b1) begin
        checks++;
        if (sbq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_strobe cyc=%0d got sp=%b tx=%b expected none", cyc, sample_pt, tx_pt);
        end else begin
          ev_t e;
          e = sbq.pop_front();
          if (e.cyc != cyc || e.kind !== {tx_pt, sample_pt}) begin
            errors++;
            $display("FAIL strobe got cyc=%0d kind=%b expected cyc=%0d kind=%b",
                     cyc, {tx_pt, sample_pt}, e.cyc, e.kind);
          end else if (e.kind == 2'b01) begin
            bv_pending = 1'b1;
            bv_exp     = e.bv;
          end
        end
      end
    end
  end

  task automatic push_ev(input int c, input logic [1:0] k, input logic b);
    ev_t e;
    e.cyc = c; e.kind = k; e.bv = b;
    sbq.push_back(e);
  endtask

  task automatic do_reset();
    mon_en = 1'b0; bv_pending = 1'b0; sbq.delete();
    rst = 1'b1; en = 1'b1; hard_sync_en = 1'b0; rx = 1'b1;
    brp = 6'd1; tseg1 = 4'd5; tseg2 = 3'd2; sjw = 2'd1;
    @(posedge clk); #1;
    rst = 1'b0; cyc = 1; mon_en = 1'b1;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
    cyc = cyc + 1;
  endtask

  task automatic end_check(input string name);
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL %s missing_strobes got %0d left expected 0 (next cyc=%0d)", name, sbq.size(), sbq[0].cyc);
    end
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks += 5;
    if (seg !== 2'd0)      begin errors++; $display("FAIL reset_seg got %0d expected 0", seg); end
    if (tq_tick !== 1'b0)  begin errors++; $display("FAIL reset_tq_tick got %b expected 0", tq_tick); end
    if (sample_pt !== 1'b0) begin errors++; $display("FAIL reset_sample_pt got %b expected 0", sample_pt); end
    if (tx_pt !== 1'b0)    begin errors++; $display("FAIL reset_tx_pt got %b expected 0", tx_pt); end
    if (bit_val !== 1'b1)  begin errors++; $display("FAIL reset_bit_val got %b expected 1", bit_val); end
    next_cycle();
  endtask

  task automatic test_nominal();
    do_reset();
    for (int b = 0; b < 3; b++) begin
      push_ev(14 + 20 * b, 2'b01, 1'b1);
      push_ev(20 + 20 * b, 2'b10, 1'b1);
    end
    for (int c = 1; c <= 60; c++) begin
      #1;
      checks++;
      if (tq_tick !== ((c % 2) == 0)) begin
        errors++; $display("FAIL nominal_tq_tick cyc=%0d got %b expected %b", c, tq_tick, (c % 2) == 0);
      end
      next_cycle();
    end
    end_check("nominal");
  endtask

  task automatic test_hard_sync();
    do_reset();
    push_ev(19, 2'b01, 1'b0); push_ev(25, 2'b10, 1'b0);
    push_ev(39, 2'b01, 1'b0); push_ev(45, 2'b10, 1'b0);
    hard_sync_en = 1'b1;
    for (int c = 1; c <= 50; c++) begin
      if (c == 7) rx = 1'b0;
      if (c == 9) hard_sync_en = 1'b0;
      #1;
      if (c == 8) begin
        checks += 2;
        if (seg !== 2'd1)     begin errors++; $display("FAIL hsync_seg got %0d expected 1", seg); end
        if (tq_tick !== 1'b0) begin errors++; $display("FAIL hsync_no_tick got %b expected 0", tq_tick); end
      end
      if (c == 9) begin
        checks++;
        if (tq_tick !== 1'b1) begin errors++; $display("FAIL hsync_first_tick got %b expected 1", tq_tick); end
      end
      next_cycle();
    end
    end_check("hard_sync");
  endtask

  task automatic test_late_edge();
    do_reset();
`ifdef BIT_TIMING_RESYNC_EN
    push_ev(18, 2'b01, 1'b0); push_ev(24, 2'b10, 1'b0);
    push_ev(38, 2'b01, 1'b0); push_ev(44, 2'b10, 1'b0);
`else
    push_ev(14, 2'b01, 1'b0); push_ev(20, 2'b10, 1'b0);
    push_ev(34, 2'b01, 1'b0); push_ev(40, 2'b10, 1'b0);
`endif
    for (int c = 1; c <= 44; c++) begin
      if (c == 9) rx = 1'b0;
      #1;
      next_cycle();
    end
    end_check("late_edge");
  endtask

  task automatic test_early_edge();
    logic [1:0] seg19_exp;
    do_reset();
`ifdef BIT_TIMING_RESYNC_EN
    seg19_exp = 2'd1;
    push_ev(14, 2'b01, 1'b1); push_ev(18, 2'b10, 1'b1);
    push_ev(30, 2'b01, 1'b0); push_ev(36, 2'b10, 1'b0);
    push_ev(50, 2'b01, 1'b0); push_ev(56, 2'b10, 1'b0);
`else
    seg19_exp = 2'd2;
    push_ev(14, 2'b01, 1'b1); push_ev(20, 2'b10, 1'b1);
    push_ev(34, 2'b01, 1'b0); push_ev(40, 2'b10, 1'b0);
    push_ev(54, 2'b01, 1'b0);
`endif
    for (int c = 1; c <= 56; c++) begin
      if (c == 17) rx = 1'b0;
      #1;
      if (c == 18) begin
        checks++;
        if (seg !== 2'd2) begin errors++; $display("FAIL early_seg18 got %0d expected 2", seg); end
      end
      if (c == 19) begin
        checks++;
        if (seg !== seg19_exp) begin errors++; $display("FAIL early_seg19 got %0d expected %0d", seg, seg19_exp); end
      end
      next_cycle();
    end
    end_check("early_edge");
  endtask

  task automatic test_config_change();
    do_reset();
    push_ev(14, 2'b01, 1'b1); push_ev(20, 2'b10, 1'b1);
    push_ev(34, 2'b01, 1'b1); push_ev(44, 2'b10, 1'b1);
    push_ev(58, 2'b01, 1'b1); push_ev(68, 2'b10, 1'b1);
    for (int c = 1; c <= 68; c++) begin
      if (c == 5) tseg2 = 3'd4;
      #1;
      next_cycle();
    end
    end_check("config_change");
  endtask

  task automatic test_enable();
    do_reset();
    push_ev(20, 2'b01, 1'b1); push_ev(26, 2'b10, 1'b1);
    push_ev(40, 2'b01, 1'b1); push_ev(46, 2'b10, 1'b1);
    for (int c = 1; c <= 46; c++) begin
      en = !(c >= 5 && c <= 10);
      #1;
      if (c >= 5 && c <= 10) begin
        checks += 2;
        if (tq_tick !== 1'b0) begin errors++; $display("FAIL en_low_tick cyc=%0d got %b expected 0", c, tq_tick); end
        if (seg !== 2'd1)     begin errors++; $display("FAIL en_low_seg cyc=%0d got %0d expected 1", c, seg); end
      end
      if (c == 12) begin
        checks++;
        if (tq_tick !== 1'b1) begin errors++; $display("FAIL en_resume_tick got %b expected 1", tq_tick); end
      end
      next_cycle();
    end
    end_check("enable");
  endtask

  task automatic test_reset_mid_seg2();
    do_reset();
    push_ev(14, 2'b01, 1'b0);
    for (int c = 1; c <= 40; c++) begin
      if (c == 1) rx = 1'b0;
      if (c == 17) rst = 1'b1;
      if (c == 18) begin
        #1;
        checks += 5;
        if (seg !== 2'd0)       begin errors++; $display("FAIL rst_mid_seg got %0d expected 0", seg); end
        if (tq_tick !== 1'b0)   begin errors++; $display("FAIL rst_mid_tick got %b expected 0", tq_tick); end
        if (sample_pt !== 1'b0) begin errors++; $display("FAIL rst_mid_sample got %b expected 0", sample_pt); end
        if (tx_pt !== 1'b0)     begin errors++; $display("FAIL rst_mid_tx got %b expected 0", tx_pt); end
        if (bit_val !== 1'b1)   begin errors++; $display("FAIL rst_mid_bit_val got %b expected 1", bit_val); end
        end_check("reset_mid_seg2");
        rst = 1'b0;
        push_ev(31, 2'b01, 1'b0); push_ev(37, 2'b10, 1'b0);
      end else begin
        #1;
      end
      next_cycle();
    end
    end_check("after_reset");
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_hard_sync();
    test_late_edge();
    test_early_edge();
    test_config_change();
    test_enable();
    test_reset_mid_seg2();
    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
